// File: rtl/kf8237_service_sequencer.sv
// 8237 DMA service sequencer: HRQ/HLDA handshake, S0..S4 transfer cycles, DACK and EOP.
// All state advances on the falling edge of clock so it lines up with the priority encoder.
module kf8237_service_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] internal_data_bus,
    input  logic       write_command_register,
    input  logic       write_mode_register,
    input  logic       master_clear,
    input  logic [3:0] encoded_dma,
    input  logic       hold_acknowledge,
    input  logic       terminal_count,
    input  logic       end_of_process_n,
    output logic       hold_request,
    output logic [3:0] dma_acknowledge_internal,
    output logic [3:0] dma_acknowledge,
    output logic       end_of_process_internal,
    output logic       end_of_process_out_n,
    output logic [3:0] cycle_state,
    output logic [1:0] dma_rotate
);

    typedef enum logic [2:0] {
        StIdle,
        StS0,
        StS1,
        StS2,
        StS3,
        StS4,
        StCascade
    } state_t;

    localparam logic [1:0] ModeDemand  = 2'b00;
    localparam logic [1:0] ModeSingle  = 2'b01;
    localparam logic [1:0] ModeBlock   = 2'b10;
    localparam logic [1:0] ModeCascade = 2'b11;

    state_t          state_q, state_d;
    logic [1:0]      channel_q, channel_d;
    logic [1:0]      svc_mode_q, svc_mode_d;
    logic [1:0]      rotate_q, rotate_d;
    logic            dack_sense_q;
    logic [3:0][1:0] mode_reg_q;
    logic [1:0]      win_index;
    logic            eop_request;

    always_comb begin
        win_index = 2'd0;
        case (encoded_dma)
            4'b0010: win_index = 2'd1;
            4'b0100: win_index = 2'd2;
            4'b1000: win_index = 2'd3;
            default: win_index = 2'd0;
        endcase
    end

    assign eop_request = terminal_count | ~end_of_process_n;

    always_comb begin
        state_d    = state_q;
        channel_d  = channel_q;
        svc_mode_d = svc_mode_q;
        rotate_d   = rotate_q;
        unique case (state_q)
            StIdle: begin
                if (encoded_dma != 4'b0000) state_d = StS0;
            end
            StS0: begin
                if (encoded_dma == 4'b0000) begin
                    state_d = StIdle;
                end else if (hold_acknowledge) begin
                    // Mode is captured here so later register writes cannot disturb this service.
                    channel_d  = win_index;
                    svc_mode_d = mode_reg_q[win_index];
                    state_d    = (mode_reg_q[win_index] == ModeCascade) ? StCascade : StS1;
                end
            end
            StS1: state_d = StS2;
            StS2: state_d = StS3;
            StS3: state_d = StS4;
            StS4: begin
                state_d = StIdle;
                if (!eop_request && hold_acknowledge) begin
                    case (svc_mode_q)
                        ModeBlock:  state_d = StS1;
                        ModeDemand: state_d = encoded_dma[channel_q] ? StS1 : StIdle;
                        default:    state_d = StIdle;
                    endcase
                end
                if (state_d == StIdle) rotate_d = channel_q + 2'd1;
            end
            StCascade: begin
                if (!encoded_dma[channel_q]) begin
                    state_d  = StIdle;
                    rotate_d = channel_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(negedge clock) begin
        if (reset || master_clear) begin
            state_q    <= StIdle;
            channel_q  <= 2'd0;
            svc_mode_q <= ModeDemand;
            rotate_q   <= 2'd0;
        end else begin
            state_q    <= state_d;
            channel_q  <= channel_d;
            svc_mode_q <= svc_mode_d;
            rotate_q   <= rotate_d;
        end
    end

    always_ff @(negedge clock) begin
        if (reset || master_clear) begin
            dack_sense_q <= 1'b0;
        end else if (write_command_register) begin
            dack_sense_q <= internal_data_bus[7];
        end
    end

    // Mode registers survive master_clear; only a hard reset clears them.
    always_ff @(negedge clock) begin
        if (reset) begin
            mode_reg_q <= '0;
        end else if (write_mode_register) begin
            mode_reg_q[internal_data_bus[1:0]] <= internal_data_bus[7:6];
        end
    end

    always_comb begin
        hold_request             = (state_q != StIdle);
        dma_acknowledge_internal = 4'b0000;
        cycle_state              = 4'b0000;
        case (state_q)
            StS1:      cycle_state = 4'b0001;
            StS2:      cycle_state = 4'b0010;
            StS3:      cycle_state = 4'b0100;
            StS4:      cycle_state = 4'b1000;
            default:   cycle_state = 4'b0000;
        endcase
        if (state_q inside {StS1, StS2, StS3, StS4, StCascade}) begin
            dma_acknowledge_internal = 4'b0001 << channel_q;
        end
        end_of_process_internal = (state_q == StS4) && eop_request;
        end_of_process_out_n    = !((state_q == StS4) && terminal_count);
        dma_acknowledge         = dack_sense_q ? dma_acknowledge_internal
                                               : ~dma_acknowledge_internal;
        dma_rotate              = rotate_q;
    end

endmodule

// File: tb/tb_kf8237_service_sequencer.sv
// Scoreboard bench for the service sequencer: each service is one transaction, closed when HRQ drops.
module tb_kf8237_service_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] internal_data_bus;
    logic       write_command_register;
    logic       write_mode_register;
    logic       master_clear;
    logic [3:0] encoded_dma;
    logic       hold_acknowledge;
    logic       terminal_count;
    logic       end_of_process_n;
    logic       hold_request;
    logic [3:0] dma_acknowledge_internal;
    logic [3:0] dma_acknowledge;
    logic       end_of_process_internal;
    logic       end_of_process_out_n;
    logic [3:0] cycle_state;
    logic [1:0] dma_rotate;

    kf8237_service_sequencer dut (
        .clock                    (clock),
        .reset                    (reset),
        .internal_data_bus        (internal_data_bus),
        .write_command_register   (write_command_register),
        .write_mode_register      (write_mode_register),
        .master_clear             (master_clear),
        .encoded_dma              (encoded_dma),
        .hold_acknowledge         (hold_acknowledge),
        .terminal_count           (terminal_count),
        .end_of_process_n         (end_of_process_n),
        .hold_request             (hold_request),
        .dma_acknowledge_internal (dma_acknowledge_internal),
        .dma_acknowledge          (dma_acknowledge),
        .end_of_process_internal  (end_of_process_internal),
        .end_of_process_out_n     (end_of_process_out_n),
        .cycle_state              (cycle_state),
        .dma_rotate               (dma_rotate)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         s_cycles;
        logic [3:0] dack;
        int         eop_int;
        int         eop_out;
        logic [1:0] rotate;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: accumulates one service while HRQ is high, compares when HRQ falls.
    bit         active = 1'b0;
    int         s_cnt, ei_cnt, eo_cnt;
    logic [3:0] dack_or;
    exp_t       e;

    always @(posedge clock) begin
        if (hold_request === 1'b1) begin
            if (!active) begin
                active  = 1'b1;
                s_cnt   = 0;
                ei_cnt  = 0;
                eo_cnt  = 0;
                dack_or = 4'b0000;
            end
            if (cycle_state != 4'b0000) s_cnt++;
            if (end_of_process_internal) ei_cnt++;
            if (!end_of_process_out_n) eo_cnt++;
            dack_or = dack_or | dma_acknowledge_internal;
        end else if (active) begin
            active = 1'b0;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_service: got 1 service, expected 0");
            end else begin
                e = exp_q.pop_front();
                check("svc_s_cycles", s_cnt, e.s_cycles);
                check("svc_dack", int'(dack_or), int'(e.dack));
                check("svc_eop_internal", ei_cnt, e.eop_int);
                check("svc_eop_out_low", eo_cnt, e.eop_out);
                check("svc_rotate", int'(dma_rotate), int'(e.rotate));
            end
        end
    end

    task automatic push(input int s, input logic [3:0] d, input int ei, input int eo,
                        input logic [1:0] r);
        exp_t x;
        x.s_cycles = s;
        x.dack     = d;
        x.eop_int  = ei;
        x.eop_out  = eo;
        x.rotate   = r;
        exp_q.push_back(x);
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_cs(input logic [3:0] cs);
        bit ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            tick();
            if (cycle_state == cs) ok = 1'b1;
        end
        if (!ok) check("timeout_cycle_state", 0, int'(cs));
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            tick();
            if (hold_request == 1'b0) ok = 1'b1;
        end
        if (!ok) check("timeout_idle", 1, 0);
        hold_acknowledge = 1'b0;
        tick();
    endtask

    task automatic wr_mode(input logic [7:0] v);
        internal_data_bus   = v;
        write_mode_register = 1'b1;
        tick();
        write_mode_register = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hrq"}, int'(hold_request), 0);
        check({tag, "_dack_int"}, int'(dma_acknowledge_internal), 0);
        check({tag, "_dack"}, int'(dma_acknowledge), 15);
        check({tag, "_cycle_state"}, int'(cycle_state), 0);
        check({tag, "_eop_int"}, int'(end_of_process_internal), 0);
        check({tag, "_eop_out_n"}, int'(end_of_process_out_n), 1);
        check({tag, "_rotate"}, int'(dma_rotate), 0);
    endtask

    initial begin
        reset                  = 1'b1;
        internal_data_bus      = 8'h00;
        write_command_register = 1'b0;
        write_mode_register    = 1'b0;
        master_clear           = 1'b0;
        encoded_dma            = 4'b0000;
        hold_acknowledge       = 1'b0;
        terminal_count         = 1'b0;
        end_of_process_n       = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Single mode, channel 2.
        wr_mode(8'h42);
        push(4, 4'b0100, 0, 0, 2'd3);
        encoded_dma = 4'b0100;
        hold_acknowledge = 1'b1;
        wait_cs(4'b0001);
        encoded_dma = 4'b0000;
        wait_idle();

        // Block mode, channel 0, terminal count on the third S4.
        wr_mode(8'h80);
        push(12, 4'b0001, 1, 1, 2'd1);
        encoded_dma = 4'b0001;
        hold_acknowledge = 1'b1;
        wait_cs(4'b0001);
        encoded_dma = 4'b0000;
        for (int k = 1; k <= 3; k++) wait_cs(4'b1000);
        terminal_count = 1'b1;
        tick();
        terminal_count = 1'b0;
        wait_idle();

        // Demand mode, channel 1, request drops during the second transfer.
        wr_mode(8'h01);
        push(8, 4'b0010, 0, 0, 2'd2);
        encoded_dma = 4'b0010;
        hold_acknowledge = 1'b1;
        wait_cs(4'b0001);
        wait_cs(4'b0001);
        encoded_dma = 4'b0000;
        wait_idle();

        // Request withdrawn in S0 before HLDA: no DACK, rotate unchanged.
        push(0, 4'b0000, 0, 0, 2'd2);
        encoded_dma = 4'b0010;
        tick();
        tick();
        encoded_dma = 4'b0000;
        wait_idle();

        // Cascade, channel 3.
        wr_mode(8'hC3);
        push(0, 4'b1000, 0, 0, 2'd0);
        encoded_dma = 4'b1000;
        hold_acknowledge = 1'b1;
        repeat (6) tick();
        encoded_dma = 4'b0000;
        wait_idle();

        // External EOP in the first S4 of a block service on channel 0.
        push(4, 4'b0001, 1, 0, 2'd1);
        encoded_dma = 4'b0001;
        hold_acknowledge = 1'b1;
        wait_cs(4'b0001);
        encoded_dma = 4'b0000;
        wait_cs(4'b1000);
        end_of_process_n = 1'b0;
        tick();
        end_of_process_n = 1'b1;
        wait_idle();

        // DACK active-high after command write 0x80.
        internal_data_bus = 8'h80;
        write_command_register = 1'b1;
        tick();
        write_command_register = 1'b0;
        check("polarity_idle_dack", int'(dma_acknowledge), 0);
        push(4, 4'b0100, 0, 0, 2'd3);
        encoded_dma = 4'b0100;
        hold_acknowledge = 1'b1;
        wait_cs(4'b0001);
        encoded_dma = 4'b0000;
        wait_cs(4'b0010);
        check("polarity_s2_dack", int'(dma_acknowledge), 4);
        wait_idle();

        // Reset in S3 of a block service.
        push(3, 4'b0001, 0, 0, 2'd0);
        encoded_dma = 4'b0001;
        hold_acknowledge = 1'b1;
        wait_cs(4'b0001);
        encoded_dma = 4'b0000;
        wait_cs(4'b0100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("reset_s3");
        wait_idle();

        // Master clear in S2 keeps block mode on channel 0.
        wr_mode(8'h80);
        push(2, 4'b0001, 0, 0, 2'd0);
        encoded_dma = 4'b0001;
        hold_acknowledge = 1'b1;
        wait_cs(4'b0001);
        encoded_dma = 4'b0000;
        wait_cs(4'b0010);
        master_clear = 1'b1;
        tick();
        master_clear = 1'b0;
        check("mclear_hrq", int'(hold_request), 0);
        check("mclear_dack", int'(dma_acknowledge), 15);
        wait_idle();

        push(8, 4'b0001, 1, 1, 2'd1);
        encoded_dma = 4'b0001;
        hold_acknowledge = 1'b1;
        wait_cs(4'b0001);
        encoded_dma = 4'b0000;
        wait_cs(4'b1000);
        wait_cs(4'b1000);
        terminal_count = 1'b1;
        tick();
        terminal_count = 1'b0;
        wait_idle();

        repeat (4) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
